mp3_sci_reader: RTL and testbench
=================================

MP3_SCI_READER -- requirements
Module: mp3_sci_reader

Interface
REQ-001 Parameter CMD_READ, default 8'h03, SCI read opcode shifted out first.
REQ-002 Parameter ADDR_W, default 4, width of SCI register address.
REQ-003 mp3_clk  input  1  block clock, 1 MHz, shared with the mp3 BGM writer.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request one SCI register read; sampled only in IDLE.
REQ-006 addr  input  ADDR_W  SCI register address; captured with start.
REQ-007 DREQ  input  1  mp3 chip ready flag; high = SCI may be accessed.
REQ-008 MISO  input  1  serial data from mp3 chip.
REQ-009 CS  output  1  SCI chip select, active-low.
REQ-010 SCLK  output  1  SPI clock, idle low.
REQ-011 MOSI  output  1  serial command/address to mp3 chip.
REQ-012 busy  output  1  high from start acceptance until the cycle done is asserted.
REQ-013 done  output  1  one-cycle pulse; rdata valid.
REQ-014 rdata  output  16  last register value read.

Function
REQ-015 All outputs SHALL be registered; SCLK = mp3_clk/2 while shifting.
REQ-016 States SHALL be IDLE, WAIT_DREQ, CS_SETUP, SHIFT_OUT, SHIFT_IN, CS_HOLD, DONE.
REQ-017 IDLE: start=1 SHALL capture {CMD_READ, 8-bit zero-extended addr} into a 16-bit shift register, set busy, go WAIT_DREQ.
REQ-018 WAIT_DREQ: stays while DREQ=0, no timeout; DREQ=1 SHALL drive CS=0 and go CS_SETUP.
REQ-019 CS_SETUP SHALL last exactly 1 cycle with SCLK=0.
REQ-020 Each bit SHALL occupy 2 cycles: phase A SCLK=0 with MOSI driven to the bit, phase B SCLK=1; MSB first.
REQ-021 SHIFT_OUT SHALL send 16 bits (opcode then address); then SHIFT_IN.
REQ-022 SHIFT_IN SHALL hold MOSI=0, generate 16 SCLK periods, sample MISO on the mp3_clk edge that drives SCLK 0->1, shift into an internal register MSB first.
REQ-023 After the 16th SHIFT_IN bit, CS_HOLD SHALL keep CS=0, SCLK=0 for 1 cycle.
REQ-024 DONE SHALL drive CS=1, load rdata from the internal register, pulse done for 1 cycle, clear busy in the same cycle, return to IDLE.
REQ-025 Latency: done SHALL assert exactly 67 mp3_clk cycles after the edge accepting start when DREQ is already 1; each DREQ=0 cycle in WAIT_DREQ adds 1.
REQ-026 start while busy SHALL be ignored, never queued; addr changes after acceptance SHALL have no effect.
REQ-027 DREQ SHALL be ignored once CS_SETUP is entered (transaction completes regardless).
REQ-028 start asserted in the DONE cycle SHALL be ignored; start in the next cycle (IDLE) SHALL be accepted.
REQ-029 rdata SHALL change only in DONE; holds value otherwise.
REQ-030 Bus sharing with the writer is arbitrated externally using busy; block SHALL NOT inspect writer signals.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=16'h0000, shift registers cleared.
REQ-032 Reset mid-transaction SHALL abort without a done pulse; first start after rst=1 SHALL run a full transaction.

Verification
REQ-033 DREQ=1, start with addr=4'h4, MISO model returns 16'h1A2B -> MOSI stream 16'h0304, done at cycle 67, rdata=16'h1A2B, 32 SCLK rising edges, CS low throughout.
REQ-034 DREQ=0 for 10 cycles after start -> CS stays 1, SCLK idle; done at cycle 77 after start.
REQ-035 start pulsed at cycles 5 and 40 of a transaction, addr changed -> single transaction, MOSI address unchanged, one done pulse.
REQ-036 rst=0 at cycle 30 of a read -> CS=1, SCLK=0, busy=0 in the same cycle, no done; rdata=0; subsequent read of addr 4'h0 returning 16'h0800 completes normally.
REQ-037 Back-to-back reads: start held high continuously, MISO returns 16'hFFFF then 16'h0001 -> two transactions, second accepted the cycle after done, rdata 16'hFFFF then 16'h0001, CS high for at least 1 cycle between.
REQ-038 DREQ dropped to 0 during SHIFT_IN -> transaction completes unchanged at cycle 67.

Source files
------------

// File: rtl/mp3_sci_reader.sv
// SCI register reader for the mp3 decoder: waits for DREQ, shifts out {CMD_READ, addr},
// then clocks in a 16-bit register value. SCLK runs at half of mp3_clk; all outputs are registered.
module mp3_sci_reader #(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter int         ADDR_W   = 4
) (
  input  logic              mp3_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              DREQ,
  input  logic              MISO,
  output logic              CS,
  output logic              SCLK,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DREQ,
    CS_SETUP,
    SHIFT_OUT,
    SHIFT_IN,
    CS_HOLD,
    DONE
  } state_t;

  state_t      state_reg;
  logic [15:0] shift_out_reg;
  logic [15:0] shift_in_reg;
  logic [3:0]  bit_cnt_reg;
  logic        cs_reg;
  logic        sclk_reg;
  logic        mosi_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [15:0] rdata_reg;

  logic [7:0]  addr_ext;
  assign addr_ext = 8'(addr);

  // Within SHIFT_OUT/SHIFT_IN, sclk_reg itself tells the phase: low = phase A, high = phase B.
  always_ff @(posedge mp3_clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      shift_out_reg <= 16'h0000;
      shift_in_reg  <= 16'h0000;
      bit_cnt_reg   <= 4'd0;
      cs_reg        <= 1'b1;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rdata_reg     <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          cs_reg   <= 1'b1;
          sclk_reg <= 1'b0;
          mosi_reg <= 1'b0;
          done_reg <= 1'b0;
          if (start) begin
            shift_out_reg <= {CMD_READ, addr_ext};
            shift_in_reg  <= 16'h0000;
            bit_cnt_reg   <= 4'd0;
            busy_reg      <= 1'b1;
            state_reg     <= WAIT_DREQ;
          end
        end

        WAIT_DREQ: begin
          if (DREQ) begin
            cs_reg    <= 1'b0;
            state_reg <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          sclk_reg      <= 1'b0;
          mosi_reg      <= shift_out_reg[15];
          shift_out_reg <= {shift_out_reg[14:0], 1'b0};
          bit_cnt_reg   <= 4'd0;
          state_reg     <= SHIFT_OUT;
        end

        SHIFT_OUT: begin
          if (!sclk_reg) begin
            sclk_reg <= 1'b1;
          end else begin
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == 4'd15) begin
              mosi_reg    <= 1'b0;
              bit_cnt_reg <= 4'd0;
              state_reg   <= SHIFT_IN;
            end else begin
              mosi_reg      <= shift_out_reg[15];
              shift_out_reg <= {shift_out_reg[14:0], 1'b0};
              bit_cnt_reg   <= bit_cnt_reg + 4'd1;
            end
          end
        end

        SHIFT_IN: begin
          mosi_reg <= 1'b0;
          if (!sclk_reg) begin
            // Sample on the same edge that raises SCLK; the slave has held this bit for a full phase.
            sclk_reg     <= 1'b1;
            shift_in_reg <= {shift_in_reg[14:0], MISO};
          end else begin
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == 4'd15) begin
              bit_cnt_reg <= 4'd0;
              state_reg   <= CS_HOLD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
        end

        CS_HOLD: begin
          cs_reg    <= 1'b1;
          sclk_reg  <= 1'b0;
          rdata_reg <= shift_in_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= DONE;
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          cs_reg    <= 1'b1;
          sclk_reg  <= 1'b0;
          mosi_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign CS    = cs_reg;
  assign SCLK  = sclk_reg;
  assign MOSI  = mosi_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_mp3_sci_reader.sv
// Randomised scoreboard bench for mp3_sci_reader with a behavioural SPI slave model.
`timescale 1ns/1ps
module tb_mp3_sci_reader;

  logic        mp3_clk = 1'b0;
  logic        rst     = 1'b0;
  logic        start   = 1'b0;
  logic [3:0]  addr    = 4'h0;
  logic        DREQ    = 1'b1;
  logic        MISO    = 1'b0;
  logic        CS, SCLK, MOSI, busy, done;
  logic [15:0] rdata;

  mp3_sci_reader dut (
    .mp3_clk(mp3_clk), .rst(rst), .start(start), .addr(addr), .DREQ(DREQ), .MISO(MISO),
    .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .busy(busy), .done(done), .rdata(rdata)
  );

  always #500 mp3_clk = ~mp3_clk;

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] miso_q[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          done_cnt = 0;

  always @(posedge mp3_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // SPI mode-0 slave: captures 16 command bits, then presents the reply word MSB first.
  int          rises = 0;
  int          mosi_hi_in = 0;
  logic [15:0] mosi_cap = 16'h0;
  logic [15:0] cur_word = 16'h0;

  always @(negedge CS) begin
    rises = 0;
    mosi_hi_in = 0;
    mosi_cap = 16'h0;
    cur_word = (miso_q.size() != 0) ? miso_q.pop_front() : 16'hDEAD;
    MISO = 1'b0;
  end

  always @(posedge SCLK) begin
    chk("cs_low_on_sclk", {31'b0, CS}, 32'd0);
    if (rises < 16) mosi_cap = {mosi_cap[14:0], MOSI};
    else if (MOSI) mosi_hi_in++;
    rises++;
    if (rises >= 16 && rises < 32) MISO = cur_word[31 - rises];
    else MISO = 1'b0;
  end

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge mp3_clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", {16'b0, rdata}, {16'b0, e.data});
        chk("mosi_cmd", {16'b0, mosi_cap}, {16'b0, e.cmd});
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("sclk_rises", 32'(rises), 32'd32);
        chk("mosi_zero_in_read", 32'(mosi_hi_in), 32'd0);
        chk("busy_clear_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  function automatic logic [15:0] cmd_of(input logic [3:0] a);
    return {8'h03, 4'h0, a};
  endfunction

  task automatic start_read(input logic [3:0] a, input logic [15:0] d, input int k, output int acc);
    exp_t e;
    @(negedge mp3_clk);
    addr  = a;
    start = 1'b1;
    DREQ  = (k == 0);
    miso_q.push_back(d);
    @(posedge mp3_clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    e.cmd = cmd_of(a); e.data = d; e.acc = acc; e.lat = 67 + k;
    sb.push_back(e);
    for (int j = 0; j < k; j++) begin
      @(negedge mp3_clk);
      chk("wait_cs_high", {30'b0, CS, SCLK}, 32'h2);
      @(posedge mp3_clk);
      #1;
    end
    DREQ = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge mp3_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge mp3_clk);
    #1;
  endtask

  initial begin
    #(2_000_000 * 1000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, d0;
    exp_t e;
    repeat (3) @(posedge mp3_clk);
    #1;
    chk("reset_outputs", {27'b0, CS, SCLK, MOSI, busy, done}, 32'h10);
    chk("reset_rdata", {16'b0, rdata}, 32'h0);
    @(negedge mp3_clk);
    rst = 1'b1;

    // Basic read with DREQ already high.
    start_read(4'h4, 16'h1A2B, 0, acc);
    wait_done();

    // DREQ held low for 10 cycles after acceptance.
    start_read(4'h9, 16'h7E81, 10, acc);
    wait_done();

    // Extra start pulses with new addresses mid-transaction are ignored.
    d0 = done_cnt;
    start_read(4'h7, 16'h5A5A, 0, acc);
    repeat (4) @(posedge mp3_clk);
    @(negedge mp3_clk); start = 1'b1; addr = 4'h9;
    @(posedge mp3_clk); #1; start = 1'b0;
    repeat (34) @(posedge mp3_clk);
    @(negedge mp3_clk); start = 1'b1; addr = 4'hF;
    @(posedge mp3_clk); #1; start = 1'b0;
    wait_done();
    repeat (80) @(posedge mp3_clk);
    chk("single_done", 32'(done_cnt - d0), 32'd1);

    // Asynchronous reset in the middle of a read aborts it.
    d0 = done_cnt;
    start_read(4'h5, 16'hBEEF, 0, acc);
    repeat (29) @(posedge mp3_clk);
    @(negedge mp3_clk);
    rst = 1'b0;
    #1;
    chk("abort_outputs", {27'b0, CS, SCLK, MOSI, busy, done}, 32'h10);
    chk("abort_rdata", {16'b0, rdata}, 32'h0);
    sb.delete();
    miso_q.delete();
    repeat (3) @(posedge mp3_clk);
    @(negedge mp3_clk);
    rst = 1'b1;
    repeat (70) @(posedge mp3_clk);
    chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    start_read(4'h0, 16'h0800, 0, acc);
    wait_done();

    // Back-to-back with start held high: second accepted the cycle after done.
    @(negedge mp3_clk);
    addr = 4'h1; start = 1'b1; DREQ = 1'b1;
    miso_q.push_back(16'hFFFF);
    miso_q.push_back(16'h0001);
    @(posedge mp3_clk);
    #1;
    acc = cyc;
    addr = 4'h2;
    e.cmd = cmd_of(4'h1); e.data = 16'hFFFF; e.acc = acc; e.lat = 67;
    sb.push_back(e);
    e.cmd = cmd_of(4'h2); e.data = 16'h0001; e.acc = acc + 69; e.lat = 67;
    sb.push_back(e);
    repeat (68) @(posedge mp3_clk);
    #1;
    chk("gap_cs_high_busy_low", {30'b0, CS, busy}, 32'h2);
    @(posedge mp3_clk);
    #1;
    start = 1'b0;
    chk("second_accepted", {31'b0, busy}, 32'd1);
    wait_done();

    // DREQ dropping during the read phase has no effect.
    start_read(4'hB, 16'hC3A5, 0, acc);
    repeat (39) @(posedge mp3_clk);
    #1; DREQ = 1'b0;
    repeat (20) @(posedge mp3_clk);
    #1; DREQ = 1'b1;
    wait_done();

    // Randomised reads with random DREQ stall lengths.
    for (int i = 0; i < 10; i++) begin
      start_read(4'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 6)), acc);
      wait_done();
      repeat ($urandom_range(0, 3)) @(posedge mp3_clk);
    end

    repeat (5) @(posedge mp3_clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
